// File: rtl/grant_pkg.sv
// Shared definitions for the request/grant mux family: drop counter width and
// grant-vector helpers (one-hot check, one-hot to index).
package grant_pkg;

  localparam int DROP_CNT_W = 8;
  localparam int GRANT_MAX_W = 32;

  function automatic logic is_onehot(input logic [GRANT_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

  // Index of the lowest set bit; only meaningful when the vector is one-hot.
  function automatic int onehot_to_idx(input logic [GRANT_MAX_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = GRANT_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_demux_chan_fifo2.sv
// Two-entry FIFO for one return channel; the head register is the output, so it
// keeps its last value once the channel drains.
module chan_fifo2
  import grant_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             full
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == 2'd2);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != 2'd0);
  assign rdata   = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      // A push lands directly in the head slot whenever the head is free or being vacated.
      if (push_ok && ((count == 2'd0) || ((count == 2'd1) && pop_ok))) begin
        head <= wdata;
      end else if (pop_ok && (count == 2'd2)) begin
        head <= tail;
      end
      if (push_ok && (count == 2'd1) && !pop_ok) begin
        tail <= wdata;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/grant_demux.sv
// Return-path demultiplexer: steers each word to the channel named by its one-hot
// grant, and drops/counts words whose grant is malformed.
module grant_demux
  import grant_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [N-1:0]          in_grant,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [N*WIDTH-1:0]    out_data,
  output logic                  err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic             onehot;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     full;
  logic [N-1:0]     push;
  logic             drop;
  logic [WIDTH-1:0] head [N];
  logic [1:0]       count [N];

  assign onehot = is_onehot(GRANT_MAX_W'(in_grant));
  assign sel    = SEL_W'(onehot_to_idx(GRANT_MAX_W'(in_grant)));

  // Malformed grants are always taken so a bad word can never stall the link.
  assign in_ready = onehot ? !full[sel] : 1'b1;
  assign drop     = in_valid && !onehot;

  always_comb begin
    push = '0;
    if (in_valid && in_ready && onehot) push = in_grant;
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    chan_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .wdata (in_data),
      .pop   (out_ready[i]),
      .rdata (head[i]),
      .count (count[i]),
      .full  (full[i])
    );
    assign out_valid[i]                = (count[i] != 2'd0);
    assign out_data[i*WIDTH +: WIDTH]  = head[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_cnt != {DROP_CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_grant_demux.sv
// Self-checking bench for grant_demux: a per-channel scoreboard queue is filled as
// words are accepted and drained as the DUT hands heads to consumers.
module tb_grant_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [3:0]  in_grant;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic        err;
  logic [7:0]  drop_cnt;

  int          errors;
  int          checks;
  logic [3:0]  sb [4][$];
  logic        exp_err;
  int          exp_drop;
  logic        acc;

  grant_demux #(.WIDTH(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_grant  (in_grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check against the model, then update the model
  // with the handshakes that will occur at the coming posedge.
  task automatic applyStimulus(input logic v, input logic [3:0] g, input logic [3:0] d,
                               input logic [3:0] r, output logic accepted);
    logic       oh;
    logic       rdy;
    int         idx;
    logic [3:0] expv;
    @(negedge clk);
    in_valid = v; in_grant = g; in_data = d; out_ready = r;
    #1;
    oh  = ($countones(g) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    rdy = oh ? (sb[idx].size() < 2) : 1'b1;
    for (int i = 0; i < 4; i++) expv[i] = (sb[i].size() != 0);
    checkOutput("in_ready", 32'(in_ready), 32'(rdy));
    checkOutput("out_valid", 32'(out_valid), 32'(expv));
    checkOutput("err", 32'(err), 32'(exp_err));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    for (int i = 0; i < 4; i++) begin
      if (expv[i]) begin
        checkOutput($sformatf("ch%0d_head", i), 32'(out_data[i*4 +: 4]), 32'(sb[i][0]));
        if (r[i]) void'(sb[i].pop_front());
      end
    end
    accepted = v && rdy && oh;
    if (accepted) sb[idx].push_back(d);
    if (v && !oh) begin
      exp_err = 1'b1;
      if (exp_drop < 255) exp_drop++;
    end
  endtask

  task automatic sendWord(input logic [3:0] g, input logic [3:0] d, input logic [3:0] r);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 10 && !a; k++) applyStimulus(1'b1, g, d, r, a);
    if (!a) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) sb[i].delete();
    exp_err  = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; exp_err = 1'b0; exp_drop = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_grant = '0; in_data = '0; out_ready = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    #2 rst_n = 1'b1;

    // Fill channel 2 with back-pressure, then drain in order.
    applyStimulus(1'b1, 4'b0100, 4'd1, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0100, 4'd2, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0100, 4'd3, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0100, 4'd3, 4'b0000, acc);
    sendWord(4'b0100, 4'd3, 4'b0100);
    repeat (4) applyStimulus(1'b0, 4'b0000, 4'd0, 4'b0100, acc);

    // Streaming on channel 0 with the consumer always ready.
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 4'b0001, 4'(k + 5), 4'b0001, acc);
    repeat (2) applyStimulus(1'b0, 4'b0000, 4'd0, 4'b0001, acc);

    // Malformed grants, then saturation of the drop counter.
    applyStimulus(1'b1, 4'b0000, 4'hA, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0110, 4'hB, 4'b0000, acc);
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0000, acc);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, (k % 2 == 0) ? 4'b1111 : 4'b0011, 4'(k), 4'b0000, acc);
    end
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0000, acc);

    // Channel 1 full, channel 3 empty: alternate grants, then pop channel 1.
    applyStimulus(1'b1, 4'b0010, 4'h1, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0010, 4'h2, 4'b0000, acc);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, (k % 2 == 0) ? 4'b0010 : 4'b1000, 4'(k + 8), 4'b0000, acc);
    end
    applyStimulus(1'b1, 4'b0010, 4'hE, 4'b0010, acc);
    applyStimulus(1'b1, 4'b0010, 4'hE, 4'b0000, acc);
    repeat (4) applyStimulus(1'b0, 4'b0000, 4'h0, 4'b1010, acc);

    // Reset with channels 0 and 3 holding two words each.
    applyStimulus(1'b1, 4'b0001, 4'h3, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0001, 4'h4, 4'b0000, acc);
    applyStimulus(1'b1, 4'b1000, 4'h5, 4'b0000, acc);
    applyStimulus(1'b1, 4'b1000, 4'h6, 4'b0000, acc);
    applyStimulus(1'b1, 4'b0000, 4'h7, 4'b0000, acc);
    pulseReset();
    sendWord(4'b1000, 4'h9, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'b1000, acc);
    applyStimulus(1'b0, 4'b0000, 4'h0, 4'b0000, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
